// File: rtl/ram_test_pkg.sv
// Shared types and pattern generator for the RAM march test master.
// Pure definitions; no latency, no backpressure.
package ram_test_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Address bit 8 folds into the byte so both RAM halves get distinct data.
    function automatic logic [7:0] pat(input logic [8:0] a, input logic [7:0] seed, input logic p);
        return (a[7:0] ^ seed ^ {8{a[8]}}) ^ {8{p}};
    endfunction

endpackage

// File: rtl/ram_march_master_if.sv
// CPU-side memory bus between the march master and the block RAM.
// Plain wires; read data returns one cycle after the address, no backpressure.
interface ram_march_master_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] AB;
    logic [DATA_W-1:0] DO;
    logic [DATA_W-1:0] DI;
    logic              CS;
    logic              WE;

    modport master (output AB, output DO, output CS, output WE, input DI);
    modport slave  (input AB, input DO, input CS, input WE, output DI);
endinterface

// File: rtl/ram_check_pipe.sv
// Read-return stage: compares DI one cycle after each read, counts and logs miscompares.
// Results land one cycle after the data returns; no backpressure.
module ram_check_pipe
    import ram_test_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 rd_vld,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic [DATA_W-1:0]    di,
    input  logic [7:0]           seed,
    input  logic                 pass,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    fail_addr,
    output logic [DATA_W-1:0]    fail_data
);

    logic              vld_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] exp_dat;
    logic              miss;

    assign exp_dat = DATA_W'(pat(9'(addr_q), seed, pass));
    assign miss    = vld_q && (di != exp_dat);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            vld_q     <= 1'b0;
            addr_q    <= '0;
            error     <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            vld_q  <= rd_vld;
            addr_q <= rd_addr;
            if (miss) begin
                error <= 1'b1;
                if (err_count != '1)
                    err_count <= err_count + 1'b1;
                // error still low means this is the first miscompare of the run
                if (!error) begin
                    fail_addr <= addr_q;
                    fail_data <= di;
                end
            end
        end
    end

endmodule

// File: rtl/ram_march_master.sv
// Two-pass write/read-verify march over the block RAM, one access per cycle.
// Busy for 2*(2*DEPTH+1) cycles per run; start is ignored while busy.
module ram_march_master
    import ram_test_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           seed,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    fail_addr,
    output logic [DATA_W-1:0]    fail_data,
    ram_march_master_if.master   bus
);

    localparam logic [ADDR_W:0] TERM_CNT = (ADDR_W+1)'(DEPTH);

    state_e          state;
    logic [ADDR_W:0] addr;
    logic [ADDR_W:0] addr_inc;
    logic            last;
    logic            pass;
    logic [7:0]      seed_q;
    logic            start_ok;

    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
    assign addr_inc = addr + 1'b1;
    assign last     = (addr_inc == TERM_CNT);
    // addr holds the location currently on the bus; it parks at DEPTH-1 after the last read
    assign bus.AB   = addr[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            addr   <= '0;
            pass   <= 1'b0;
            seed_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bus.CS <= 1'b0;
            bus.WE <= 1'b0;
            bus.DO <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state  <= ST_WRITE;
                        seed_q <= seed;
                        pass   <= 1'b0;
                        addr   <= '0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        bus.CS <= 1'b1;
                        bus.WE <= 1'b1;
                        bus.DO <= DATA_W'(pat(9'd0, seed, 1'b0));
                    end
                end
                ST_WRITE: begin
                    if (last) begin
                        state  <= ST_READ;
                        addr   <= '0;
                        bus.WE <= 1'b0;
                    end else begin
                        addr   <= addr_inc;
                        bus.DO <= DATA_W'(pat(9'(addr_inc), seed_q, pass));
                    end
                end
                ST_READ: begin
                    if (last) begin
                        state  <= ST_DRAIN;
                        bus.CS <= 1'b0;
                    end else begin
                        addr <= addr_inc;
                    end
                end
                ST_DRAIN: begin
                    if (!pass) begin
                        state  <= ST_WRITE;
                        pass   <= 1'b1;
                        addr   <= '0;
                        bus.CS <= 1'b1;
                        bus.WE <= 1'b1;
                        bus.DO <= DATA_W'(pat(9'd0, seed_q, 1'b1));
                    end else begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ram_check_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_check (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .rd_vld    (bus.CS & ~bus.WE),
        .rd_addr   (bus.AB),
        .di        (bus.DI),
        .seed      (seed_q),
        .pass      (pass),
        .error     (error),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );

endmodule
